// File: rtl/l1_cache_control_if.sv
// CPU-side and memory-side handshake bundle for the L1 cache controller.
// master = requester/memory side (testbench or core), slave = the controller.
interface l1_cache_control_if;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/l1_cache_control.sv
// 2-way set-associative L1 controller: hit compare, word merge, writeback/allocate FSM, per-set LRU.
// Optional hit/miss performance counters are built when L1_PERF_COUNTERS_EN is defined.
module l1_cache_control (
    input  logic                     clk,
    input  logic                     reset,
    l1_cache_control_if.slave        bus,
    output logic [2:0]               way_index,
    output logic [8:0]               way_tag_in,
    output logic [127:0]             way_data_in,
    output logic [3:0]               way0_array_write,
    output logic [3:0]               way1_array_write,
    output logic                     way0_dirty_in,
    output logic                     way1_dirty_in,
    input  logic                     way0_valid,
    input  logic                     way0_dirty,
    input  logic                     way1_valid,
    input  logic                     way1_dirty,
    input  logic [8:0]               way0_tag,
    input  logic [8:0]               way1_tag,
    input  logic [127:0]             way0_data,
    input  logic [127:0]             way1_data,
    output logic [15:0]              hit_count,
    output logic [15:0]              miss_count
);
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t       state;
    logic [7:0]   lru;

    logic [8:0]   req_tag;
    logic [2:0]   req_idx;
    logic [2:0]   req_word;
    logic         req;
    logic         hit0;
    logic         hit1;
    logic         hit;
    logic         hit_way;
    logic         victim;
    logic         vic_valid;
    logic         vic_dirty;
    logic [8:0]   vic_tag;
    logic [127:0] vic_data;
    logic [127:0] hit_line;
    logic         unused_addr_lsb;

    function automatic logic [127:0] merge_word(input logic [127:0] line,
                                                input logic [2:0]   word,
                                                input logic [1:0]   be,
                                                input logic [15:0]  wdata);
        logic [127:0] r;
        r = line;
        if (be[0]) r[{word, 4'h0} +: 8] = wdata[7:0];
        if (be[1]) r[{word, 4'h8} +: 8] = wdata[15:8];
        return r;
    endfunction

    assign req_tag         = bus.mem_address[15:7];
    assign req_idx         = bus.mem_address[6:4];
    assign req_word        = bus.mem_address[3:1];
    assign unused_addr_lsb = bus.mem_address[0];
    assign way_index       = req_idx;
    assign way_tag_in      = req_tag;

    assign req      = bus.mem_read | bus.mem_write;
    assign hit0     = way0_valid & (way0_tag == req_tag);
    assign hit1     = way1_valid & (way1_tag == req_tag);
    assign hit      = hit0 | hit1;
    // Way 0 wins if both ever matched, so the select is a single bit.
    assign hit_way  = ~hit0;
    assign hit_line = hit_way ? way1_data : way0_data;

    // Invalid ways are filled before the LRU choice is consulted.
    assign victim    = !way0_valid ? 1'b0 : (!way1_valid ? 1'b1 : lru[req_idx]);
    assign vic_valid = victim ? way1_valid : way0_valid;
    assign vic_dirty = victim ? way1_dirty : way0_dirty;
    assign vic_tag   = victim ? way1_tag   : way0_tag;
    assign vic_data  = victim ? way1_data  : way0_data;

    assign bus.mem_rdata = hit_line[{req_word, 4'h0} +: 16];

    always_comb begin
        bus.mem_resp     = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = {bus.mem_address[15:4], 4'h0};
        bus.pmem_wdata   = vic_data;
        way_data_in      = merge_word(hit_line, req_word, bus.mem_byte_enable, bus.mem_wdata);
        way0_array_write = 4'b0000;
        way1_array_write = 4'b0000;
        way0_dirty_in    = (state == IDLE);
        way1_dirty_in    = (state == IDLE);
        case (state)
            IDLE: begin
                if (req && hit) begin
                    bus.mem_resp = 1'b1;
                    if (bus.mem_write) begin
                        if (hit_way) way1_array_write = 4'b1001;
                        else         way0_array_write = 4'b1001;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {vic_tag, req_idx, 4'h0};
            end
            ALLOCATE: begin
                bus.pmem_read = 1'b1;
                way_data_in   = bus.pmem_rdata;
                if (bus.pmem_resp) begin
                    if (victim) way1_array_write = 4'b1111;
                    else        way0_array_write = 4'b1111;
                end
            end
            default: ;
        endcase
        // A fill arriving in the reset cycle must not be installed.
        if (reset) begin
            bus.mem_resp     = 1'b0;
            bus.pmem_read    = 1'b0;
            bus.pmem_write   = 1'b0;
            way0_array_write = 4'b0000;
            way1_array_write = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            lru   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (hit)                         lru[req_idx] <= ~hit_way;
                        else if (vic_valid && vic_dirty) state <= WRITEBACK;
                        else                             state <= ALLOCATE;
                    end
                end
                WRITEBACK: if (bus.pmem_resp) state <= ALLOCATE;
                ALLOCATE: begin
                    if (bus.pmem_resp) begin
                        lru[req_idx] <= ~victim;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef L1_PERF_COUNTERS_EN
    logic hit_evt;
    logic miss_evt;
    assign hit_evt  = (state == IDLE) && req && hit;
    assign miss_evt = (state == IDLE) && req && !hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
        end else begin
            if (hit_evt  && hit_count  != 16'hFFFF) hit_count  <= hit_count  + 16'd1;
            if (miss_evt && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
    end
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif
endmodule

// File: tb/tb_l1_cache_control.sv
// Bench for l1_cache_control: models the two way arrays and physical memory, and checks
// every response against a flat word memory plus a per-set recency list of resident lines.
module tb_l1_cache_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    l1_cache_control_if bus();

    logic [2:0]   way_index;
    logic [8:0]   way_tag_in;
    logic [127:0] way_data_in;
    logic [3:0]   way0_array_write, way1_array_write;
    logic         way0_dirty_in, way1_dirty_in;
    logic         way0_valid, way0_dirty, way1_valid, way1_dirty;
    logic [8:0]   way0_tag, way1_tag;
    logic [127:0] way0_data, way1_data;
    logic [15:0]  hit_count, miss_count;

    l1_cache_control dut (
        .clk(clk), .reset(reset), .bus(bus),
        .way_index(way_index), .way_tag_in(way_tag_in), .way_data_in(way_data_in),
        .way0_array_write(way0_array_write), .way1_array_write(way1_array_write),
        .way0_dirty_in(way0_dirty_in), .way1_dirty_in(way1_dirty_in),
        .way0_valid(way0_valid), .way0_dirty(way0_dirty),
        .way1_valid(way1_valid), .way1_dirty(way1_dirty),
        .way0_tag(way0_tag), .way1_tag(way1_tag),
        .way0_data(way0_data), .way1_data(way1_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // Way arrays: synchronous strobed writes, asynchronous read of the indexed set.
    logic [127:0] arr_data [2][8];
    logic [8:0]   arr_tag  [2][8];
    logic [7:0]   arr_valid [2] = '{8'h00, 8'h00};
    logic [7:0]   arr_dirty [2] = '{8'h00, 8'h00};

    always @(posedge clk) begin
        if (way0_array_write[0]) arr_data[0][way_index]  <= way_data_in;
        if (way0_array_write[1]) arr_tag[0][way_index]   <= way_tag_in;
        if (way0_array_write[2]) arr_valid[0][way_index] <= 1'b1;
        if (way0_array_write[3]) arr_dirty[0][way_index] <= way0_dirty_in;
        if (way1_array_write[0]) arr_data[1][way_index]  <= way_data_in;
        if (way1_array_write[1]) arr_tag[1][way_index]   <= way_tag_in;
        if (way1_array_write[2]) arr_valid[1][way_index] <= 1'b1;
        if (way1_array_write[3]) arr_dirty[1][way_index] <= way1_dirty_in;
    end

    assign way0_data  = arr_data[0][way_index];
    assign way1_data  = arr_data[1][way_index];
    assign way0_tag   = arr_tag[0][way_index];
    assign way1_tag   = arr_tag[1][way_index];
    assign way0_valid = arr_valid[0][way_index];
    assign way1_valid = arr_valid[1][way_index];
    assign way0_dirty = arr_dirty[0][way_index];
    assign way1_dirty = arr_dirty[1][way_index];

    // Reference: flat word memory, backing line store, and per-set MRU-first resident list.
    typedef struct packed { logic [8:0] tag; logic dirty; } ent_t;
    ent_t          mq [8][$];
    logic [15:0]   ref_mem [logic [14:0]];
    logic [127:0]  pmem    [logic [11:0]];
    int            exp_hits = 0;
    int            exp_misses = 0;
    int            n_pass = 0;
    int            n_total = 0;
    logic [15:0]   last_rdata;
    logic [15:0]   last_wb_addr;
    logic [15:0]   last_rd_addr;
    logic          wb_seen;

    function automatic logic [15:0] pat(input logic [14:0] wa);
        logic [31:0] t;
        t = {17'b0, wa} * 32'd40503;
        return t[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] ref_get(input logic [14:0] wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return pat(wa);
    endfunction

    function automatic logic [127:0] pmem_get(input logic [11:0] l);
        logic [127:0] r;
        if (pmem.exists(l)) return pmem[l];
        for (int w = 0; w < 8; w++) r[w*16 +: 16] = pat({l, 3'(w)});
        return r;
    endfunction

    function automatic logic [127:0] ref_line(input logic [11:0] l);
        logic [127:0] r;
        for (int w = 0; w < 8; w++) r[w*16 +: 16] = ref_get({l, 3'(w)});
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_counters(input string tag);
`ifdef L1_PERF_COUNTERS_EN
        chk({tag, "_hits"},   128'(hit_count),  128'(exp_hits));
        chk({tag, "_misses"}, 128'(miss_count), 128'(exp_misses));
`else
        chk({tag, "_hits"},   128'(hit_count),  128'(0));
        chk({tag, "_misses"}, 128'(miss_count), 128'(0));
`endif
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] v);
        logic [127:0] l;
        l = pmem_get(a[15:4]);
        l[{a[3:1], 4'h0} +: 16] = v;
        pmem[a[15:4]] = l;
        ref_mem[a[15:1]] = v;
    endtask

    task automatic do_req(input logic wr, input logic [15:0] a, input logic [1:0] be,
                          input logic [15:0] wd);
        logic [2:0]   s;
        logic [8:0]   t;
        int           pos;
        logic         hit;
        logic         ewb;
        logic [15:0]  wbaddr;
        logic [127:0] wbline;
        logic [127:0] fill;
        logic [15:0]  old_w;
        logic [15:0]  new_w;
        int           wbn;
        int           aln;
        ent_t         e;
        s = a[6:4];
        t = a[15:7];
        pos = -1;
        for (int i = 0; i < mq[s].size(); i++) if (mq[s][i].tag == t) pos = i;
        hit = (pos >= 0);
        ewb = 1'b0;
        wbaddr = 16'h0;
        wbline = '0;
        if (!hit && mq[s].size() == 2) begin
            ewb    = mq[s][1].dirty;
            wbaddr = {mq[s][1].tag, s, 4'h0};
            wbline = ref_line({mq[s][1].tag, s});
        end
        wb_seen = 1'b0;
        wbn = int'($urandom_range(1, 3));
        aln = int'($urandom_range(1, 3));
        old_w = ref_get(a[15:1]);
        new_w = {be[1] ? wd[15:8] : old_w[15:8], be[0] ? wd[7:0] : old_w[7:0]};

        @(posedge clk); #1;
        bus.mem_address     = a;
        bus.mem_write       = wr;
        bus.mem_read        = wr ? ($urandom_range(0, 1) == 1) : 1'b1;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
        if (!hit) begin
            @(negedge clk);
            chk("miss_first_cycle", 128'({bus.mem_resp, bus.pmem_read, bus.pmem_write}), 128'(0));
            if (ewb) begin
                for (int i = 0; i < wbn; i++) begin
                    @(posedge clk); #1;
                    bus.pmem_resp = (i == wbn - 1);
                    @(negedge clk);
                    chk("wb_req", 128'({bus.pmem_write, bus.pmem_read, bus.mem_resp}), 128'(3'b100));
                    chk("wb_addr", 128'(bus.pmem_address), 128'(wbaddr));
                    chk("wb_data", bus.pmem_wdata, wbline);
                    chk("wb_no_strobe", 128'({way0_array_write, way1_array_write}), 128'(0));
                end
                pmem[wbaddr[15:4]] = bus.pmem_wdata;
                wb_seen = 1'b1;
                last_wb_addr = bus.pmem_address;
            end
            fill = pmem_get(a[15:4]);
            for (int i = 0; i < aln; i++) begin
                @(posedge clk); #1;
                bus.pmem_resp  = (i == aln - 1);
                bus.pmem_rdata = fill;
                @(negedge clk);
                chk("alloc_req", 128'({bus.pmem_write, bus.pmem_read, bus.mem_resp}), 128'(3'b010));
                chk("alloc_addr", 128'(bus.pmem_address), 128'({a[15:4], 4'h0}));
                last_rd_addr = bus.pmem_address;
            end
            chk("fill_strobe", 128'(({way0_array_write, way1_array_write} == 8'hF0) ||
                                    ({way0_array_write, way1_array_write} == 8'h0F)), 128'(1));
            chk("fill_data", way_data_in, fill);
            chk("fill_clean", 128'(way0_array_write[3] ? way0_dirty_in : way1_dirty_in), 128'(0));
            @(posedge clk); #1;
            bus.pmem_resp = 1'b0;
            exp_misses++;
            if (mq[s].size() == 2) void'(mq[s].pop_back());
            e.tag = t;
            e.dirty = 1'b0;
            mq[s].push_front(e);
            pos = 0;
        end
        @(negedge clk);
        chk("resp", 128'({bus.mem_resp, bus.pmem_read, bus.pmem_write}), 128'(3'b100));
        chk("way_index", 128'(way_index), 128'(a[6:4]));
        chk("way_tag_in", 128'(way_tag_in), 128'(a[15:7]));
        if (!wr) begin
            chk("rdata", 128'(bus.mem_rdata), 128'(old_w));
        end else begin
            chk("wr_strobe", 128'(({way0_array_write, way1_array_write} == 8'h90) ||
                                  ({way0_array_write, way1_array_write} == 8'h09)), 128'(1));
            chk("wr_word", 128'(way_data_in[{a[3:1], 4'h0} +: 16]), 128'(new_w));
            chk("wr_dirty", 128'(way0_array_write[3] ? way0_dirty_in : way1_dirty_in), 128'(1));
            ref_mem[a[15:1]] = new_w;
        end
        last_rdata = bus.mem_rdata;
        exp_hits++;
        e = mq[s][pos];
        mq[s].delete(pos);
        e.dirty = e.dirty | wr;
        mq[s].push_front(e);
        @(posedge clk); #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        @(negedge clk);
        chk("idle_quiet", 128'({bus.mem_resp, bus.pmem_read, bus.pmem_write,
                                way0_array_write, way1_array_write}), 128'(0));
    endtask

    initial begin
        logic [8:0] tags [4];
        tags = '{9'h000, 9'h0A5, 9'h133, 9'h1FF};
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_byte_enable = 2'b00;
        bus.mem_address = 16'h0;
        bus.mem_wdata = 16'h0;
        bus.pmem_rdata = '0;
        bus.pmem_resp = 1'b0;
        last_rdata = 16'h0;
        last_wb_addr = 16'h0;
        last_rd_addr = 16'h0;
        wb_seen = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 128'({bus.mem_resp, bus.pmem_read, bus.pmem_write,
                                   way0_array_write, way1_array_write}), 128'(0));
        chk_counters("reset");

        // Reset while ALLOCATE is pending on a cold set
        @(posedge clk); #1;
        bus.mem_read = 1'b1;
        bus.mem_address = 16'h5550;
        @(negedge clk);
        chk("rst_miss_c0", 128'(bus.mem_resp), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_alloc_pending", 128'(bus.pmem_read), 128'(1));
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_cycle_no_strobe", 128'({way0_array_write, way1_array_write}), 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        bus.mem_read = 1'b0;
        @(negedge clk);
        chk("rst_req_dropped", 128'({bus.pmem_read, bus.pmem_write, way0_array_write,
                                     way1_array_write}), 128'(0));
        @(posedge clk); #1;
        bus.pmem_resp = 1'b1;
        bus.pmem_rdata = pmem_get(12'h555);
        @(negedge clk);
        chk("late_resp_ignored", 128'({bus.pmem_read, way0_array_write, way1_array_write}), 128'(0));
        @(posedge clk); #1;
        bus.pmem_resp = 1'b0;
        @(negedge clk);
        chk("late_resp_not_installed", 128'({arr_valid[0][5], arr_valid[1][5]}), 128'(0));
        chk_counters("after_reset");

        // Directed sequence on set 3
        preload(16'h0A32, 16'hBEEF);
        do_req(1'b0, 16'h0A32, 2'b00, 16'h0);
        chk("cold_rdata", 128'(last_rdata), 128'(16'hBEEF));
        chk("cold_alloc_addr", 128'(last_rd_addr), 128'(16'h0A30));
        chk("cold_way0_filled", 128'({arr_valid[0][3], arr_valid[1][3]}), 128'(2'b10));
        do_req(1'b1, 16'h0A32, 2'b01, 16'h1234);
        chk("write_hit_dirty", 128'(arr_dirty[0][3]), 128'(1));
        do_req(1'b0, 16'h0A32, 2'b00, 16'h0);
        chk("byte_merge_readback", 128'(last_rdata), 128'(16'hBE34));
        do_req(1'b0, 16'h1A30, 2'b00, 16'h0);
        chk("second_fill_no_wb", 128'(wb_seen), 128'(0));
        chk("second_fill_way1", 128'({arr_valid[1][3], arr_tag[1][3]}), 128'({1'b1, 9'h034}));
        do_req(1'b0, 16'h2A30, 2'b00, 16'h0);
        chk("evict_wb_seen", 128'(wb_seen), 128'(1));
        chk("evict_wb_addr", 128'(last_wb_addr), 128'(16'h0A30));
        chk("evict_way0_retag", 128'({arr_tag[0][3], arr_dirty[0][3]}), 128'({9'h054, 1'b0}));
        chk_counters("directed");

        // Randomized traffic over four tags per set
        for (int n = 0; n < 60; n++) begin
            logic [15:0] a;
            a = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
            do_req($urandom_range(0, 1) == 1, a, 2'($urandom_range(0, 3)), 16'($urandom));
            if ($urandom_range(0, 3) == 0) @(posedge clk);
        end
        chk_counters("random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/l1_cache_control.md
# l1_cache_control

Controller and word-select datapath for the 2-way set-associative L1 cache. Sits directly upstream of the two `L1_cache_way` instances: it decodes CPU requests, performs the hit compare against both ways, and drives their array write strobes, tag, index and line data. It also runs the writeback and allocate handshakes to physical memory and keeps per-set LRU state.

## Interface
Parameters: none. Geometry is fixed: 8 sets, 2 ways, 16-byte lines, 16-bit address split as tag[15:7], index[6:4], word[3:1]; bit 0 is ignored.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- mem_read, mem_write  in  1 each  CPU request; held stable until mem_resp
- mem_byte_enable  in  2  byte lanes for writes
- mem_address  in  16  CPU byte address
- mem_wdata  in  16  write word
- mem_rdata  out  16  read word; valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- pmem_read, pmem_write  out  1 each  line request to memory
- pmem_address  out  16  line address, low 4 bits are 0
- pmem_wdata  out  128  victim line
- pmem_rdata  in  128  fill line
- pmem_resp  in  1  memory completion pulse
- way_index  out  3  shared set index, equal to mem_address[6:4]
- way_tag_in  out  9  shared tag, equal to mem_address[15:7]
- way_data_in  out  128  shared line write data
- way0_array_write, way1_array_write  out  4 each  strobes: bit 0 data, 1 tag, 2 valid, 3 dirty
- way0_dirty_in, way1_dirty_in  out  1 each
- way0_valid, way0_dirty, way1_valid, way1_dirty  in  1 each
- way0_tag, way1_tag  in  9 each
- way0_data, way1_data  in  128 each  asynchronous read of the indexed set
- hit_count, miss_count  out  16 each  performance counters (see Configuration)

## Operation
- State register values: IDLE, WRITEBACK, ALLOCATE.
- LRU storage: an 8-bit register `lru`; `lru[i]` holds the number of the way to evict next in set i.
- hitN = wayN_valid & (wayN_tag == mem_address[15:7]).
- Victim way: if way 0 is invalid, way 0; otherwise if way 1 is invalid, way 1; otherwise lru[index].
- IDLE, no request: all strobes and pmem requests are 0.
- IDLE, read hit:
  - mem_resp=1.
  - mem_rdata = word[3:1] of the hit way's line.
  - lru[index] <= other way.
- IDLE, write hit:
  - mem_resp=1.
  - way_data_in = hit line with the enabled bytes of mem_wdata merged at word[3:1].
  - Hit way strobes = 4'b1001, dirty_in=1.
  - lru[index] <= other way.
- IDLE, miss: no response. Go to WRITEBACK if the victim is valid and dirty, else to ALLOCATE.
- WRITEBACK:
  - pmem_write=1.
  - pmem_address = {victim tag, index, 4'b0}.
  - pmem_wdata = victim data.
  - On pmem_resp, go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1.
  - pmem_address = {mem_address[15:4], 4'b0}.
  - On pmem_resp: way_data_in = pmem_rdata, victim strobes = 4'b1111, dirty_in=0, lru[index] <= other way, go to IDLE.
  - The request then hits on the following cycle.
- If mem_read and mem_write are both asserted, the request is treated as a write.
- In WRITEBACK and ALLOCATE the victim is recomputed each cycle from held inputs. Victim state cannot change because no strobes fire before pmem_resp.

## Timing
- Reset values:
  - state=IDLE, lru=8'h00.
  - mem_resp, pmem_read, pmem_write and all strobes are 0.
  - Counters are 0.
  - Way array contents are not cleared by reset.
- Hit latency: mem_resp rises in the same cycle the request is presented in IDLE. Write data commits on that edge.
- Clean miss: 1 (IDLE) + N (ALLOCATE, until pmem_resp) + 1 (IDLE hit) cycles.
- Dirty miss: adds the WRITEBACK cycles before ALLOCATE.
- pmem_read and pmem_write are held constant, with a stable address, until the cycle pmem_resp=1. Both fall on the following edge.
- pmem_resp outside WRITEBACK and ALLOCATE is ignored.
- Reset mid-miss: next state is IDLE and pmem requests drop. The line being fetched is not installed. A completed writeback leaves the victim marked dirty, which is harmless.

## Configuration
- `L1_PERF_COUNTERS_EN` defined:
  - hit_count increments on each IDLE hit response.
  - miss_count increments on each IDLE to WRITEBACK/ALLOCATE transition.
  - Both are 16-bit and saturate at 16'hFFFF.
- `L1_PERF_COUNTERS_EN` undefined: no counter flops; hit_count and miss_count are tied to 0.

## Test plan
- Cold read: after reset, read 16'h0A32. Expect ALLOCATE with pmem_address 16'h0A30. Return a line whose word 1 is 16'hBEEF. Expect mem_resp one cycle after pmem_resp with mem_rdata 16'hBEEF, way0 filled, lru[3]=1.
- Write hit with byte enables: after the cold read above, write 16'h1234 with byte_enable 2'b01 to 16'h0A32. Expect mem_resp in the same cycle, word reads back 16'hBE34, way0 dirty=1.
- Second way fill: read 16'h1A30, same set, new tag. Expect fill into way1 and lru[3]=0, with no writeback.
- Dirty eviction: read 16'h2A30. Expect way0 victim; WRITEBACK at pmem_address 16'h0A30 with the modified line, then ALLOCATE at 16'h2A30, then hit.
- Reset during ALLOCATE: assert reset with pmem_read high. Next cycle expect pmem_read=0, state IDLE, no strobes. A later pmem_resp is ignored.
- Counters (macro defined): 3 hits and 2 misses. Expect hit_count=3 and miss_count=2. With the macro undefined, both read 0.
